// File: rtl/pipe_add_pkg.sv
// Shared types and constant helpers for the pipelined adder/subtractor.
// Saturation values are used only when PIPE_ADD_SAT_EN is defined.
package pipe_add_pkg;

  typedef struct packed {
    logic cout;
    logic ovfl;
    logic zero;
    logic neg;
  } flags_t;

  function automatic logic [63:0] SAT_MAX(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] SAT_MIN(input int w);
    return 64'd1 << (w - 1);
  endfunction

  function automatic bit PARAMS_OK(input int w, input int s);
    return (s >= 1) && (w >= s) && ((w % s) == 0);
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipe_add_add_slice.sv
// W-bit ripple-carry slice built from full_adder cells; also exposes the
// carry into its MSB so the final slice can derive signed overflow.
module add_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         cmsb
);

  // Each bit owns its carry wires so the ripple is a chain of distinct nets.
  for (genvar i = 0; i < W; i++) begin : g_bit
    logic ci;
    logic co;
    if (i == 0) begin : g_first
      assign ci = cin;
    end else begin : g_rest
      assign ci = g_bit[i-1].co;
    end
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (ci),
      .sum  (sum[i]),
      .cout (co)
    );
  end

  assign cout = g_bit[W-1].co;
  assign cmsb = g_bit[W-1].ci;

endmodule

// File: rtl/pipe_add.sv
// Pipelined WIDTH-bit adder/subtractor, one ripple slice per stage, with
// valid/ready backpressure. Optional signed saturation via PIPE_ADD_SAT_EN.
module pipe_add
  import pipe_add_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovfl,
  output logic             zero,
  output logic             neg
);

  localparam int SW = WIDTH / STAGES;

  if (!PARAMS_OK(WIDTH, STAGES)) begin : g_bad_params
    $error("pipe_add: WIDTH must be a positive multiple of STAGES");
  end

  logic [STAGES-1:0] v_q, v_d, adv;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic              c_q [STAGES];
  logic              cm_q;

  logic [SW-1:0] sl_a  [STAGES];
  logic [SW-1:0] sl_b  [STAGES];
  logic [SW-1:0] sl_s  [STAGES];
  logic          sl_ci [STAGES];
  logic          sl_co [STAGES];
  logic          sl_cm [STAGES];

  logic [WIDTH-1:0] b_in;
  assign b_in = sub ? ~b : b;

  // A stage moves when any stage from it to the tail is empty, or the tail drains.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] s_prev;

    assign adv[k] = out_ready || !(&v_q[STAGES-1:k]);

    if (k == 0) begin : g_entry
      assign sl_a[k]  = a[SW-1:0];
      assign sl_b[k]  = b_in[SW-1:0];
      assign sl_ci[k] = sub | cin;
      assign v_d[k]   = in_valid;
      assign a_d[k]   = a;
      assign b_d[k]   = b_in;
      assign s_prev   = '0;
    end else begin : g_mid
      assign sl_a[k]  = a_q[k-1][k*SW +: SW];
      assign sl_b[k]  = b_q[k-1][k*SW +: SW];
      assign sl_ci[k] = c_q[k-1];
      assign v_d[k]   = v_q[k-1];
      assign a_d[k]   = a_q[k-1];
      assign b_d[k]   = b_q[k-1];
      assign s_prev   = s_q[k-1];
    end

    add_slice #(.W(SW)) u_slice (
      .a    (sl_a[k]),
      .b    (sl_b[k]),
      .cin  (sl_ci[k]),
      .sum  (sl_s[k]),
      .cout (sl_co[k]),
      .cmsb (sl_cm[k])
    );

    assign s_d[k] = (s_prev & ~(WIDTH'({SW{1'b1}}) << (k*SW)))
                  | (WIDTH'(sl_s[k]) << (k*SW));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q  <= '0;
      cm_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
    end else begin
      if (adv[STAGES-1]) cm_q <= sl_cm[STAGES-1];
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          v_q[k] <= v_d[k];
          a_q[k] <= a_d[k];
          b_q[k] <= b_d[k];
          s_q[k] <= s_d[k];
          c_q[k] <= sl_co[k];
        end
      end
    end
  end

  flags_t           fl;
  logic [WIDTH-1:0] raw, res;

  always_comb begin
    raw     = s_q[STAGES-1];
    fl.cout = c_q[STAGES-1];
    fl.ovfl = cm_q ^ c_q[STAGES-1];
    res     = raw;
`ifdef PIPE_ADD_SAT_EN
    // On overflow the true sign is the opposite of the wrapped MSB.
    if (fl.ovfl) res = raw[WIDTH-1] ? WIDTH'(SAT_MAX(WIDTH)) : WIDTH'(SAT_MIN(WIDTH));
`endif
    fl.zero = (res == '0);
    fl.neg  = res[WIDTH-1];
  end

  assign in_ready  = adv[0];
  assign out_valid = v_q[STAGES-1];
  assign sum       = res;
  assign cout      = fl.cout;
  assign ovfl      = fl.ovfl;
  assign zero      = fl.zero;
  assign neg       = fl.neg;

endmodule

// File: tb/tb_pipe_add.sv
// Self-checking bench for pipe_add (WIDTH=16, STAGES=4): directed cases,
// backpressure, mid-stream reset and a randomized scoreboard run.
module tb_pipe_add;

  localparam int W = 16;
  localparam int S = 4;
  localparam longint MOD  = 64'd1 << W;
  localparam longint HALF = 64'd1 << (W - 1);

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [W-1:0] a, b;
  logic         cin, sub;
  logic         out_valid, out_ready;
  logic [W-1:0] sum;
  logic         cout, ovfl, zero, neg;

  int checkCount = 0;
  int errorCount = 0;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovfl;
    logic         zero;
    logic         neg;
  } expT;

  expT expQ[$];

  pipe_add #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovfl      (ovfl),
    .zero      (zero),
    .neg       (neg)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference computed on signed/unsigned integers rather than carries.
  function automatic expT refModel(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                   input logic tc, input logic ts);
    longint ua, ub, sa, sb, tr, wr;
    expT e;
    ua = longint'(ta);
    ub = longint'(tb);
    sa = (ua >= HALF) ? ua - MOD : ua;
    sb = (ub >= HALF) ? ub - MOD : ub;
    if (ts) begin
      tr = sa - sb;
      wr = ua - ub;
      e.cout = (ua >= ub);
    end else begin
      tr = sa + sb + longint'(tc);
      wr = ua + ub + longint'(tc);
      e.cout = (wr >= MOD);
    end
    e.ovfl = (tr > HALF - 1) || (tr < -HALF);
    e.sum  = wr[W-1:0];
`ifdef PIPE_ADD_SAT_EN
    if (tr > HALF - 1) e.sum = W'(HALF - 1);
    else if (tr < -HALF) e.sum = W'(HALF);
`endif
    e.zero = (e.sum == '0);
    e.neg  = e.sum[W-1];
    return e;
  endfunction

  // Scoreboard: record accepted beats, compare retiring beats in order.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedBeat", 32'(out_valid), 32'(1'b0));
        end else begin
          expT e;
          e = expQ.pop_front();
          checkOutput("sbSum",  32'(sum),  32'(e.sum));
          checkOutput("sbCout", 32'(cout), 32'(e.cout));
          checkOutput("sbOvfl", 32'(ovfl), 32'(e.ovfl));
          checkOutput("sbZero", 32'(zero), 32'(e.zero));
          checkOutput("sbNeg",  32'(neg),  32'(e.neg));
        end
      end
      if (in_valid && in_ready) expQ.push_back(refModel(a, b, cin, sub));
    end
  end

  // Offer one beat and hold it until accepted; returns just after the accepting edge.
  task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb,
                               input logic tc, input logic ts);
    int  waitCycles = 0;
    bit  done = 1'b0;
    in_valid = 1'b1;
    a = ta; b = tb; cin = tc; sub = ts;
    while (!done) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk); #1;
      waitCycles++;
      if (!done && waitCycles > 200) begin
        checkOutput("acceptTimeout", 32'(waitCycles), 32'(0));
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  // Single beat into an idle pipe, checked against fixed values with latency.
  task automatic directedBeat(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                              input logic tc, input logic ts, input logic [W-1:0] eSum,
                              input logic eCout, input logic eOvfl, input logic eZero,
                              input logic eNeg);
    in_valid = 1'b1;
    a = ta; b = tb; cin = tc; sub = ts;
    @(negedge clk);
    checkOutput({tag, "_inReady"}, 32'(in_ready), 32'(1'b1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int j = 0; j < S; j++) begin
      @(negedge clk);
      if (j < S - 1) begin
        checkOutput({tag, "_early"}, 32'(out_valid), 32'(1'b0));
      end else begin
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'(1'b1));
        checkOutput({tag, "_sum"},   32'(sum),  32'(eSum));
        checkOutput({tag, "_cout"},  32'(cout), 32'(eCout));
        checkOutput({tag, "_ovfl"},  32'(ovfl), 32'(eOvfl));
        checkOutput({tag, "_zero"},  32'(zero), 32'(eZero));
        checkOutput({tag, "_neg"},   32'(neg),  32'(eNeg));
      end
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [W-1:0] randOperand();
    logic [W-1:0] corners [4];
    corners[0] = '0;
    corners[1] = '1;
    corners[2] = W'(HALF - 1);
    corners[3] = W'(HALF);
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
    return W'($urandom);
  endfunction

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit randDone;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #2;
    checkOutput("rstOutValid", 32'(out_valid), 32'(1'b0));
    checkOutput("rstSum",      32'(sum),  32'(0));
    checkOutput("rstCout",     32'(cout), 32'(1'b0));
    checkOutput("rstOvfl",     32'(ovfl), 32'(1'b0));
    checkOutput("rstZero",     32'(zero), 32'(1'b1));
    checkOutput("rstNeg",      32'(neg),  32'(1'b0));
    checkOutput("rstInReady",  32'(in_ready), 32'(1'b1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed cases");
    directedBeat("add",     16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0, 1'b0);
    directedBeat("ripple",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    directedBeat("cinAdd",  16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
    directedBeat("cinIgn",  16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0);
    directedBeat("borrow",  16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef PIPE_ADD_SAT_EN
    directedBeat("ovfAdd",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0);
    directedBeat("ovfSub",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1);
`else
    directedBeat("ovfAdd",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
    directedBeat("ovfSub",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
`endif

    $display("[TB] backpressure stream");
    fork
      begin
        for (int i = 0; i < 10; i++)
          applyStimulus(randOperand(), randOperand(), 1'($urandom), 1'($urandom));
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          if (out_valid && expQ.size() > 0)
            checkOutput("stallHold", 32'(sum), 32'(expQ[0].sum));
          if (i == 5) begin
            checkOutput("fullInReady",  32'(in_ready),  32'(1'b0));
            checkOutput("fullOutValid", 32'(out_valid), 32'(1'b1));
            checkOutput("fullCount",    32'(expQ.size()), 32'(S));
          end
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        checkOutput("fullPassThru", 32'(in_ready), 32'(1'b1));
      end
    join
    for (int i = 0; i < 50 && expQ.size() != 0; i++) @(posedge clk);
    #1;
    checkOutput("bpDrained", 32'(expQ.size()), 32'(0));

    $display("[TB] reset mid-stream");
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(16'h0100 + 16'(i), 16'h0010, 1'b0, 1'b0);
    @(posedge clk); #1;
    checkOutput("preRstValid", 32'(out_valid), 32'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midRstValid", 32'(out_valid), 32'(1'b0));
    checkOutput("midRstZero",  32'(zero), 32'(1'b1));
    expQ.delete();
    @(posedge clk); #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("postRstInReady", 32'(in_ready), 32'(1'b1));
    directedBeat("postRst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] randomized run");
    randDone = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          applyStimulus(randOperand(), randOperand(), 1'($urandom), 1'($urandom));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
        randDone = 1'b1;
      end
      begin
        while (!randDone) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    for (int i = 0; i < 50 && expQ.size() != 0; i++) @(posedge clk);
    #1;
    checkOutput("randDrained", 32'(expQ.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
